// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_pkg
// Purpose  : Shared definitions for the ID-stage pipeline controller: FSM
//            state encoding and the hard-wired zero register index.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  localparam logic S_RUN      = 1'b0;
  localparam logic S_MUL_WAIT = 1'b1;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    ST_RUN      = S_RUN,
    ST_MUL_WAIT = S_MUL_WAIT
  } state_e;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/hazard_stall_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Up-counter that sticks at all-ones instead of wrapping.
// Ports    : clk   - rising-edge clock
//            rst   - synchronous active-high reset (clears count)
//            inc_i - increment request for this cycle
//            cnt_o - current count, CNT_W bits
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (inc_i && !(&cnt_q)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_ctrl
// Purpose  : ID-stage controller for the IF/ID and ID/EX pipeline registers.
//            Handles load-use stalls, multi-cycle multiply waits and
//            taken-branch flushes. Outputs are combinational from the FSM
//            state and the current inputs.
// Config   : HAZARD_PERF_CNT_EN - when defined, StallCnt/FlushCnt are live
//            saturating counters; otherwise both are tied to zero.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            IF_ID_RsAddr/RtAddr - source fields of the instruction in ID
//            ID_EX_RtAddr        - destination of the instruction in EX
//            ID_EX_MemRead       - instruction in EX is a load
//            ID_IsMul            - instruction in ID is a multiply
//            EX_BranchTaken      - branch in EX resolved taken
//            PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble - pipe controls
//            MulBusy             - FSM is waiting on a multiply
//            StallCnt, FlushCnt  - performance counters
// Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IF_ID_RsAddr,
  input  logic [4:0]       IF_ID_RtAddr,
  input  logic [4:0]       ID_EX_RtAddr,
  input  logic             ID_EX_MemRead,
  input  logic             ID_IsMul,
  input  logic             EX_BranchTaken,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Bubble,
  output logic             MulBusy,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam int               MCNT_W    = $clog2(MUL_LATENCY);
  // The issue cycle is free, so the wait state covers MUL_LATENCY-1 cycles,
  // counting down to and including zero.
  localparam logic [MCNT_W-1:0] MCNT_INIT = MCNT_W'(MUL_LATENCY - 2);

  state_e            state_q, state_d;
  logic [MCNT_W-1:0] mcnt_q, mcnt_d;
  logic              w_lu;

  // Load-use: a load to a real register feeding either ID source operand.
  assign w_lu = ID_EX_MemRead && (ID_EX_RtAddr != REG_ZERO) &&
                ((ID_EX_RtAddr == IF_ID_RsAddr) || (ID_EX_RtAddr == IF_ID_RtAddr));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      mcnt_q  <= mcnt_d;
    end
  end

  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    MulBusy      = 1'b0;
    state_d      = state_q;
    mcnt_d       = mcnt_q;

    if (rst) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
      state_d      = ST_RUN;
      mcnt_d       = '0;
    end else if (EX_BranchTaken) begin
      // Redirect: fetch proceeds from the target, everything younger is
      // squashed, including a multiply sitting in ID.
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
      state_d      = ST_RUN;
      mcnt_d       = '0;
    end else if (state_q == ST_MUL_WAIT) begin
      // Load-use is not checked here: EX only holds bubbles during the wait.
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
      MulBusy      = 1'b1;
      if (mcnt_q == '0) begin
        state_d = ST_RUN;
      end else begin
        mcnt_d = mcnt_q - 1'b1;
      end
    end else if (w_lu) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
    end else if (ID_IsMul) begin
      state_d = ST_MUL_WAIT;
      mcnt_d  = MCNT_INIT;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic w_stall_inc;

  assign w_stall_inc = !rst && !PCWrite;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (w_stall_inc),
    .cnt_o (StallCnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (EX_BranchTaken),
    .cnt_o (FlushCnt)
  );
`else
  assign StallCnt = '0;
  assign FlushCnt = '0;
`endif

endmodule : hazard_stall_ctrl
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_stall_ctrl
// Purpose  : Directed self-checking bench for hazard_stall_ctrl with
//            MUL_LATENCY=4. Control outputs are compared as one packed
//            vector {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MulBusy}.
// Config   : HAZARD_PERF_CNT_EN selects live or tied-off counter expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;

  localparam int CNT_W = 16;

  // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MulBusy}
  localparam logic [4:0] C_RST  = 5'b00110;
  localparam logic [4:0] C_FREE = 5'b11000;
  localparam logic [4:0] C_LU   = 5'b00010;
  localparam logic [4:0] C_MUL  = 5'b00011;
  localparam logic [4:0] C_BR   = 5'b11110;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       IF_ID_RsAddr, IF_ID_RtAddr, ID_EX_RtAddr;
  logic             ID_EX_MemRead, ID_IsMul, EX_BranchTaken;
  logic             PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MulBusy;
  logic [CNT_W-1:0] StallCnt, FlushCnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MUL_LATENCY(4), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .IF_ID_RsAddr   (IF_ID_RsAddr),
    .IF_ID_RtAddr   (IF_ID_RtAddr),
    .ID_EX_RtAddr   (ID_EX_RtAddr),
    .ID_EX_MemRead  (ID_EX_MemRead),
    .ID_IsMul       (ID_IsMul),
    .EX_BranchTaken (EX_BranchTaken),
    .PCWrite        (PCWrite),
    .IF_ID_Write    (IF_ID_Write),
    .IF_ID_Flush    (IF_ID_Flush),
    .ID_EX_Bubble   (ID_EX_Bubble),
    .MulBusy        (MulBusy),
    .StallCnt       (StallCnt),
    .FlushCnt       (FlushCnt)
  );

  function automatic logic [CNT_W-1:0] perf(input int v);
`ifdef HAZARD_PERF_CNT_EN
    return CNT_W'(v);
`else
    return '0;
`endif
  endfunction

  // Sample at the falling edge, mid-cycle.
  task automatic chk_ctl(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    @(negedge clk);
    obs = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MulBusy};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] obs,
                         input logic [CNT_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    IF_ID_RsAddr = 5'd0; IF_ID_RtAddr = 5'd0; ID_EX_RtAddr = 5'd0;
    ID_EX_MemRead = 1'b0; ID_IsMul = 1'b0; EX_BranchTaken = 1'b0;

    // 1. Two reset cycles, then idle free-run.
    chk_ctl("rst_c0", C_RST);
    next_cycle();
    chk_ctl("rst_c1", C_RST);
    next_cycle();
    rst = 1'b0;
    chk_cnt("rst_stallcnt", StallCnt, '0);
    chk_cnt("rst_flushcnt", FlushCnt, '0);
    chk_ctl("idle", C_FREE);
    next_cycle();

    // 2. Load-use on rs, then on rt, then a non-matching load.
    ID_EX_MemRead = 1'b1; ID_EX_RtAddr = 5'd8; IF_ID_RsAddr = 5'd8;
    chk_ctl("lu_rs", C_LU);
    next_cycle();
    ID_EX_MemRead = 1'b0;
    chk_ctl("lu_rs_after", C_FREE);
    next_cycle();
    ID_EX_MemRead = 1'b1; ID_EX_RtAddr = 5'd5; IF_ID_RsAddr = 5'd3; IF_ID_RtAddr = 5'd5;
    chk_ctl("lu_rt", C_LU);
    next_cycle();
    IF_ID_RtAddr = 5'd6;
    chk_ctl("load_nomatch", C_FREE);
    next_cycle();

    // 3. Load to $0 never stalls.
    ID_EX_RtAddr = 5'd0; IF_ID_RsAddr = 5'd0; IF_ID_RtAddr = 5'd0;
    chk_ctl("lu_zero", C_FREE);
    next_cycle();
    ID_EX_MemRead = 1'b0;
    chk_cnt("stall_after_lu", StallCnt, perf(2));

    // Clear counters so the multiply stall count starts from zero.
    rst = 1'b1;
    chk_ctl("rst_mid", C_RST);
    next_cycle();
    rst = 1'b0;
    chk_cnt("rst_mid_stallcnt", StallCnt, '0);

    // 4. Back-to-back multiplies: issue, 3 wait cycles, reissue, 3 waits.
    ID_IsMul = 1'b1;
    chk_ctl("mul1_issue", C_FREE);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      chk_ctl($sformatf("mul1_wait%0d", i), C_MUL);
      next_cycle();
    end
    chk_cnt("mul1_stallcnt", StallCnt, perf(3));
    chk_ctl("mul2_issue", C_FREE);
    next_cycle();
    ID_IsMul = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_ctl($sformatf("mul2_wait%0d", i), C_MUL);
      next_cycle();
    end
    chk_ctl("mul2_done", C_FREE);
    next_cycle();
    chk_cnt("mul2_stallcnt", StallCnt, perf(6));

    // 5. Multiply squashed by a same-cycle taken branch.
    ID_IsMul = 1'b1; EX_BranchTaken = 1'b1;
    chk_ctl("br_mul", C_BR);
    next_cycle();
    ID_IsMul = 1'b0; EX_BranchTaken = 1'b0;
    chk_ctl("br_after", C_FREE);
    chk_cnt("flushcnt", FlushCnt, perf(1));
    next_cycle();

    // 6. Reset on the second wait cycle abandons the multiply.
    ID_IsMul = 1'b1;
    chk_ctl("mul3_issue", C_FREE);
    next_cycle();
    ID_IsMul = 1'b0;
    chk_ctl("mul3_wait0", C_MUL);
    next_cycle();
    rst = 1'b1;
    chk_ctl("mul3_rst", C_RST);
    next_cycle();
    rst = 1'b0;
    chk_ctl("mul3_after_rst", C_FREE);
    chk_cnt("mul3_stallcnt", StallCnt, '0);
    next_cycle();

    // Wait counter restarts cleanly after the abandoned multiply.
    ID_IsMul = 1'b1;
    chk_ctl("mul4_issue", C_FREE);
    next_cycle();
    ID_IsMul = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_ctl($sformatf("mul4_wait%0d", i), C_MUL);
      next_cycle();
    end
    chk_ctl("mul4_done", C_FREE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule : tb_hazard_stall_ctrl
`default_nettype wire
